// File: rtl/pulse_train_pkg.sv
// Shared types and helpers for the pulse train generator.
package pulse_train_pkg;

    localparam int unsigned W_LEN_DEF = 8;
    localparam int unsigned W_CNT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A zero-length phase still lasts one cycle so pulses stay separable.
    function automatic int unsigned len_or_one(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/pulse_train_generator_if.sv
// Command handshake and pulse output bundle.
// PULSE_TRAIN_GENERATOR_ABORT_EN adds the abort request line.
interface pulse_train_generator_if #(
    parameter int unsigned W_LEN = 8,
    parameter int unsigned W_CNT = 8
) ();
    logic             start_valid;
    logic             start_ready;
    logic [W_LEN-1:0] high_len;
    logic [W_LEN-1:0] low_len;
    logic [W_CNT-1:0] count;
    logic             pulse_out;
    logic             busy;
    logic             done;
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    logic             abort;

    modport master (
        output start_valid, high_len, low_len, count, abort,
        input  start_ready, pulse_out, busy, done
    );
    modport slave (
        input  start_valid, high_len, low_len, count, abort,
        output start_ready, pulse_out, busy, done
    );
`else
    modport master (
        output start_valid, high_len, low_len, count,
        input  start_ready, pulse_out, busy, done
    );
    modport slave (
        input  start_valid, high_len, low_len, count,
        output start_ready, pulse_out, busy, done
    );
`endif
endinterface

// File: rtl/phase_down_counter.sv
// Loadable down-counter timing one high or low phase; saturates at zero.
module phase_down_counter #(
    parameter int unsigned W_LEN = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [W_LEN-1:0] value,
    input  logic             dec,
    output logic             is_zero
);
    logic [W_LEN-1:0] cnt_q;

    // Load takes priority; decrement stops at zero so it can never wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W_LEN'(1);
        end
    end

    assign is_zero = (cnt_q == '0);
endmodule

// File: rtl/pulse_train_generator.sv
// Pulse train generator: N pulses of H high cycles separated by L low cycles.
// Optional abort input enabled by PULSE_TRAIN_GENERATOR_ABORT_EN.
module pulse_train_generator
    import pulse_train_pkg::*;
#(
    parameter int unsigned W_LEN = W_LEN_DEF,
    parameter int unsigned W_CNT = W_CNT_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    pulse_train_generator_if.slave  bus
);
    state_t           state_q, state_d;
    logic [W_LEN-1:0] h_q, h_d;
    logic [W_LEN-1:0] l_q, l_d;
    logic [W_CNT-1:0] pcnt_q, pcnt_d;
    logic             ld, dec, ph_zero;
    logic [W_LEN-1:0] ld_val;
    logic             abort_c;
    logic             pulse_q, busy_q, done_q, ready_q;

`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    assign abort_c = bus.abort;
`else
    assign abort_c = 1'b0;
`endif

    // Shared phase timer, reloaded at every phase entry.
    phase_down_counter #(.W_LEN(W_LEN)) u_phase (
        .clk     (clk),
        .rst     (rst),
        .load    (ld),
        .value   (ld_val),
        .dec     (dec),
        .is_zero (ph_zero)
    );

    // Next-state, latched lengths (stored minus one) and remaining-pulse count.
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        l_d     = l_q;
        pcnt_d  = pcnt_q;
        ld      = 1'b0;
        ld_val  = '0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_valid && ready_q) begin
                    h_d = W_LEN'(len_or_one(32'(bus.high_len)) - 32'd1);
                    l_d = W_LEN'(len_or_one(32'(bus.low_len)) - 32'd1);
                    if (bus.count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = HIGH;
                        ld      = 1'b1;
                        ld_val  = h_d;
                        pcnt_d  = bus.count - W_CNT'(1);
                    end
                end
            end
            HIGH: begin
                if (abort_c) begin
                    state_d = DONE;
                end else if (ph_zero) begin
                    if (pcnt_q == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        ld      = 1'b1;
                        ld_val  = l_q;
                        pcnt_d  = pcnt_q - W_CNT'(1);
                    end
                end else begin
                    dec = 1'b1;
                end
            end
            LOW: begin
                if (abort_c) begin
                    state_d = DONE;
                end else if (ph_zero) begin
                    state_d = HIGH;
                    ld      = 1'b1;
                    ld_val  = h_q;
                end else begin
                    dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and outputs registered together so outputs decode the state held in the flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            h_q     <= '0;
            l_q     <= '0;
            pcnt_q  <= '0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            l_q     <= l_d;
            pcnt_q  <= pcnt_d;
            pulse_q <= (state_d == HIGH);
            busy_q  <= (state_d == HIGH) || (state_d == LOW);
            done_q  <= (state_d == DONE);
            ready_q <= (state_d == IDLE);
        end
    end

    assign bus.pulse_out   = pulse_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.start_ready = ready_q;
endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed bench for pulse_train_generator; abort scenario when PULSE_TRAIN_GENERATOR_ABORT_EN is set.
module tb_pulse_train_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    pulse_train_generator_if #(.W_LEN(8), .W_CNT(8)) bus ();

    pulse_train_generator #(.W_LEN(8), .W_CNT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=000", {bus.pulse_out, bus.busy, bus.done});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.start_ready, bus.pulse_out, bus.busy, bus.done} !== 4'b1000) begin
            failures++;
            $display("FAIL idle_after_reset got=%b exp=1000",
                     {bus.start_ready, bus.pulse_out, bus.busy, bus.done});
        end
    endtask

    task automatic test_basic();
        logic [12:0] pat;
        logic        exp_p;
        logic        prev;
        int          rises;
        pat   = 13'b1110011100111;
        prev  = 1'b0;
        rises = 0;
        @(negedge clk);
        bus.high_len = 8'd3; bus.low_len = 8'd2; bus.count = 8'd3; bus.start_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            exp_p = (k < 13) ? pat[12-k] : 1'b0;
            checks++;
            if (bus.pulse_out !== exp_p) begin
                failures++;
                $display("FAIL basic_pulse cycle=%0d got=%b exp=%b", k, bus.pulse_out, exp_p);
            end
            checks++;
            if (bus.done !== (k == 13)) begin
                failures++;
                $display("FAIL basic_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 13));
            end
            checks++;
            if (bus.busy !== (k < 13)) begin
                failures++;
                $display("FAIL basic_busy cycle=%0d got=%b exp=%b", k, bus.busy, (k < 13));
            end
            if (bus.pulse_out === 1'b1 && prev === 1'b0) rises++;
            prev = bus.pulse_out;
            if (k == 0) bus.start_valid = 1'b0;
        end
        checks++;
        if (rises != 3) begin
            failures++;
            $display("FAIL basic_rises got=%0d exp=3", rises);
        end
    endtask

    task automatic test_zero();
        logic [2:0] pat;
        logic       exp_p;
        pat = 3'b101;
        @(negedge clk);
        bus.high_len = 8'd0; bus.low_len = 8'd0; bus.count = 8'd2; bus.start_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp_p = (k < 3) ? pat[2-k] : 1'b0;
            checks++;
            if (bus.pulse_out !== exp_p) begin
                failures++;
                $display("FAIL zero_len_pulse cycle=%0d got=%b exp=%b", k, bus.pulse_out, exp_p);
            end
            checks++;
            if (bus.done !== (k == 3)) begin
                failures++;
                $display("FAIL zero_len_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 3));
            end
            if (k == 0) bus.start_valid = 1'b0;
        end
    endtask

    task automatic test_count_zero();
        @(negedge clk);
        bus.high_len = 8'd5; bus.low_len = 8'd5; bus.count = 8'd0; bus.start_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            checks++;
            if (bus.pulse_out !== 1'b0) begin
                failures++;
                $display("FAIL count0_pulse cycle=%0d got=%b exp=0", k, bus.pulse_out);
            end
            checks++;
            if (bus.done !== (k == 0)) begin
                failures++;
                $display("FAIL count0_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 0));
            end
            checks++;
            if (bus.start_ready !== (k != 0)) begin
                failures++;
                $display("FAIL count0_ready cycle=%0d got=%b exp=%b", k, bus.start_ready, (k != 0));
            end
        end
    endtask

    task automatic test_handshake();
        logic [9:0] pat;
        logic       exp_p;
        logic       prev;
        int         rises;
        int         k;
        bit         seen;
        pat   = 10'b1010011110;
        prev  = 1'b0;
        rises = 0;
        seen  = 1'b0;
        @(negedge clk);
        bus.high_len = 8'd1; bus.low_len = 8'd1; bus.count = 8'd2; bus.start_valid = 1'b1;
        @(posedge clk);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            exp_p = pat[9-k];
            checks++;
            if (bus.pulse_out !== exp_p) begin
                failures++;
                $display("FAIL hs_pulse cycle=%0d got=%b exp=%b", k, bus.pulse_out, exp_p);
            end
            checks++;
            if (bus.start_ready !== (k == 4)) begin
                failures++;
                $display("FAIL hs_ready cycle=%0d got=%b exp=%b", k, bus.start_ready, (k == 4));
            end
            checks++;
            if (bus.done !== (k == 3)) begin
                failures++;
                $display("FAIL hs_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 3));
            end
            if (k >= 4 && bus.pulse_out === 1'b1 && prev === 1'b0) rises++;
            prev = bus.pulse_out;
            if (k == 0) begin
                bus.high_len = 8'd4; bus.low_len = 8'd4; bus.count = 8'd7;
            end
            if (k == 5) bus.start_valid = 1'b0;
        end
        while (k < 120 && !seen) begin
            @(negedge clk);
            if (bus.pulse_out === 1'b1 && prev === 1'b0) rises++;
            prev = bus.pulse_out;
            if (bus.done === 1'b1) seen = 1'b1;
            else k++;
        end
        checks++;
        if (k != 57) begin
            failures++;
            $display("FAIL hs_second_done_cycle got=%0d exp=57", k);
        end
        checks++;
        if (rises != 7) begin
            failures++;
            $display("FAIL hs_second_rises got=%0d exp=7", rises);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] pat;
        pat = 2'b11;
        @(negedge clk);
        @(negedge clk);
        bus.high_len = 8'd5; bus.low_len = 8'd1; bus.count = 8'd4; bus.start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.pulse_out !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_before got=%b exp=1", bus.pulse_out);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({bus.pulse_out, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=000", {bus.pulse_out, bus.busy, bus.done});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.pulse_out, bus.done} !== 2'b00) begin
                failures++;
                $display("FAIL rstmid_hold cycle=%0d got=%b exp=00", k, {bus.pulse_out, bus.done});
            end
            if (k == 1) rst = 1'b1;
        end
        checks++;
        if (bus.start_ready !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ready got=%b exp=1", bus.start_ready);
        end
        bus.high_len = 8'd2; bus.low_len = 8'd1; bus.count = 8'd1; bus.start_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            checks++;
            if (bus.pulse_out !== ((k < 2) ? pat[1-k] : 1'b0)) begin
                failures++;
                $display("FAIL rstmid_rerun_pulse cycle=%0d got=%b exp=%b", k, bus.pulse_out, (k < 2));
            end
            checks++;
            if (bus.done !== (k == 2)) begin
                failures++;
                $display("FAIL rstmid_rerun_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 2));
            end
        end
    endtask

`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
    task automatic test_abort();
        logic [2:0] pat;
        pat = 3'b110;
        @(negedge clk);
        bus.high_len = 8'd2; bus.low_len = 8'd4; bus.count = 8'd5; bus.start_valid = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.start_valid = 1'b0;
            checks++;
            if (bus.pulse_out !== ((k < 3) ? pat[2-k] : 1'b0)) begin
                failures++;
                $display("FAIL abort_pulse cycle=%0d got=%b", k, bus.pulse_out);
            end
            checks++;
            if (bus.done !== (k == 3)) begin
                failures++;
                $display("FAIL abort_done cycle=%0d got=%b exp=%b", k, bus.done, (k == 3));
            end
            checks++;
            if (bus.start_ready !== (k >= 4)) begin
                failures++;
                $display("FAIL abort_ready cycle=%0d got=%b exp=%b", k, bus.start_ready, (k >= 4));
            end
            bus.abort = (k == 2) || (k == 4);
        end
        bus.abort = 1'b0;
    endtask
`endif

    initial begin
        bus.start_valid = 1'b0;
        bus.high_len    = '0;
        bus.low_len     = '0;
        bus.count       = '0;
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        bus.abort       = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero();
        test_count_zero();
        test_handshake();
        test_reset_mid();
`ifdef PULSE_TRAIN_GENERATOR_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
